instruction_fetch_unit: RTL and testbench
=========================================

# instruction_fetch_unit

Fetch-side producer for the single-cycle RISC-V core's control decoder. Holds the program counter, fetches one 32-bit instruction at a time from instruction memory over a valid/ready request and valid response interface, and pre-decodes the opcode into the one-hot instruction-class strobes and function fields the control decoder consumes. It then computes the next PC from the decoder's `next_pc_selector` when the downstream stage accepts the instruction.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset (word aligned)
- `clk`  in  1  single clock, all state on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `imem_req_valid`  out  1  fetch request valid
- `imem_req_ready`  in  1  memory accepts request
- `imem_req_addr`  out  32  fetch address (= `pc`)
- `imem_resp_valid`  in  1  instruction data valid (at least 1 cycle after request accept)
- `imem_resp_data`  in  32  fetched instruction word
- `instr_valid`  out  1  decoded instruction held for downstream
- `instr_ready`  in  1  downstream consumes instruction this cycle
- `instruction`  out  32  registered instruction word
- `pc`  out  32  address of current instruction
- `r_type`, `i_type_lw`, `i_type_addi`, `i_type_jalr`, `s_type`, `sb_type`, `u_type_auipc`, `u_type_lui`, `uj_type`  out  1 each  one-hot class strobes
- `func_3`  out  3  instruction[14:12]
- `func_7_bit_6`  out  1  instruction[30]
- `illegal`  out  1  opcode matches no class
- `next_pc_selector`  in  2  00 PC+4, 01 conditional branch, 10 jalr, 11 jal
- `branch_taken`  in  1  branch comparison result
- `branch_target`  in  32  PC + B-immediate (also used for jal)
- `jalr_target`  in  32  rs1 + I-immediate
- `halted`  out  1  misaligned target trap, sticky until reset

## Operation
- FSM states: REQ, WAIT, HOLD, HALT. Reset state REQ.
- REQ: `imem_req_valid`=1, `imem_req_addr`=`pc`. `imem_req_ready`=1 goes to WAIT. The address stays stable while waiting.
- WAIT: `imem_resp_valid`=1 registers `imem_resp_data` into `instruction`, registers the decode, and goes to HOLD. `imem_resp_valid` is ignored in REQ, HOLD and HALT.
- HOLD: `instr_valid`=1, outputs stable. `instr_ready`=1 computes the next PC, then goes to REQ, or to HALT on a misaligned target.
- Next PC:
  - 00: pc+4.
  - 01: `branch_taken` ? `branch_target` : pc+4.
  - 10: `jalr_target` with bit0 cleared.
  - 11: `branch_target`.
  - Arithmetic is 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.
- Misaligned: if the selected target has bits[1:0] != 0 after the jalr bit0 clear, enter HALT. `pc` is unchanged and `halted`=1. Only reset exits HALT.
- Decode from opcode instruction[6:0]:
  - 0110011 sets `r_type`.
  - 0000011 sets `i_type_lw`.
  - 0010011 sets `i_type_addi`.
  - 1100111 sets `i_type_jalr`.
  - 0100011 sets `s_type`.
  - 1100011 sets `sb_type`.
  - 0010111 sets `u_type_auipc`.
  - 0110111 sets `u_type_lui`.
  - 1101111 sets `uj_type`.
  - Any other opcode sets `illegal`=1 with all strobes 0. It is still presented, so downstream treats it as a no-write NOP.
- At most one strobe is high. Strobes, `func_3` and `func_7_bit_6` are registered with `instruction` and are meaningful only while `instr_valid`=1.

## Timing
- Reset values:
  - `pc`=`RESET_PC`, `instruction`=0.
  - All strobes, `illegal`, `instr_valid` and `halted` = 0.
  - `func_3`=0, `func_7_bit_6`=0.
  - `imem_req_valid`=1, since the state is REQ.
- After reset deasserts, the first request is visible in the first cycle.
- Minimum loop is 3 cycles per instruction: REQ accept (cycle 0), response (cycle 1), HOLD with `instr_ready` (cycle 2). The next REQ is in cycle 3.
- Response in the same cycle as request accept is out of protocol and ignored.
- `instr_valid` never drops without `instr_ready`. `instruction`, `pc` and strobes hold across stalls.
- Reset mid-WAIT discards the outstanding response. A response arriving after reset, in REQ, is ignored.
- `instr_ready` while `instr_valid`=0 has no effect.

## Test plan
- Reset with `RESET_PC`=0, memory returns 32'h00500093 (addi) with `instr_ready`=1 and selector 00 -> `i_type_addi`=1, `func_3`=0. The second request address is 32'h4 in cycle 3.
- `imem_req_ready` held low 5 cycles -> `imem_req_valid` stays 1 and the address holds 0. Then hold `instr_ready` low 4 cycles -> `instr_valid`, `instruction` and `pc` are stable.
- Fetch 32'h00208463 (beq) at pc 8 with selector 01, `branch_taken`=1, `branch_target`=32'h10 -> next request address 32'h10. Repeat with `branch_taken`=0 -> 32'hC.
- jalr with `jalr_target`=32'h41 -> next address 32'h40. jalr with `jalr_target`=32'h42 -> `halted`=1, no further requests, `pc` unchanged until `rst_n` pulses.
- Opcode 7'b1111111 -> `illegal`=1, all strobes 0, `instr_valid`=1, next address pc+4. `pc`=32'hFFFFFFFC with selector 00 -> next address 0.
- Assert `rst_n`=0 in WAIT, then drive `imem_resp_valid` in the first cycle after release -> ignored, `instr_valid` stays 0, request reissued at `RESET_PC`.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: holds the PC, fetches one instruction over a valid/ready memory port,
// pre-decodes the opcode into one-hot class strobes and computes the next PC on handoff.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instruction,
    output logic [31:0] pc,
    output logic        r_type,
    output logic        i_type_lw,
    output logic        i_type_addi,
    output logic        i_type_jalr,
    output logic        s_type,
    output logic        sb_type,
    output logic        u_type_auipc,
    output logic        u_type_lui,
    output logic        uj_type,
    output logic [2:0]  func_3,
    output logic        func_7_bit_6,
    output logic        illegal,
    input  logic [1:0]  next_pc_selector,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic [31:0] jalr_target,
    output logic        halted
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_HALT} state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc_reg;
    logic [31:0] instr_reg;
    logic [9:0]  class_reg;
    logic [31:0] pc_plus4;
    logic [31:0] target;
    logic        misaligned;

    // Class vector bit order: {illegal, uj, lui, auipc, sb, s, jalr, addi, lw, r}
    function automatic logic [9:0] decode_class(input logic [6:0] opcode);
        case (opcode)
            7'b0110011: decode_class = 10'b00_0000_0001;
            7'b0000011: decode_class = 10'b00_0000_0010;
            7'b0010011: decode_class = 10'b00_0000_0100;
            7'b1100111: decode_class = 10'b00_0000_1000;
            7'b0100011: decode_class = 10'b00_0001_0000;
            7'b1100011: decode_class = 10'b00_0010_0000;
            7'b0010111: decode_class = 10'b00_0100_0000;
            7'b0110111: decode_class = 10'b00_1000_0000;
            7'b1101111: decode_class = 10'b01_0000_0000;
            default:    decode_class = 10'b10_0000_0000;
        endcase
    endfunction

    always_comb begin
        pc_plus4 = pc_reg + 32'd4;
        case (next_pc_selector)
            2'b00:   target = pc_plus4;
            2'b01:   target = branch_taken ? branch_target : pc_plus4;
            2'b10:   target = {jalr_target[31:1], 1'b0};
            default: target = branch_target;
        endcase
        misaligned = |target[1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_REQ;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_REQ:   if (imem_req_ready) state_next = S_WAIT;
            S_WAIT:  if (imem_resp_valid) state_next = S_HOLD;
            S_HOLD:  if (instr_ready) state_next = misaligned ? S_HALT : S_REQ;
            S_HALT:  state_next = S_HALT;
            default: state_next = S_REQ;
        endcase
    end

    always_comb begin
        imem_req_valid = (state == S_REQ);
        instr_valid    = (state == S_HOLD);
        halted         = (state == S_HALT);
    end

    // A misaligned target leaves pc untouched so the trap reports the faulting instruction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg    <= RESET_PC;
            instr_reg <= 32'd0;
            class_reg <= 10'd0;
        end else begin
            if (state == S_WAIT && imem_resp_valid) begin
                instr_reg <= imem_resp_data;
                class_reg <= decode_class(imem_resp_data[6:0]);
            end
            if (state == S_HOLD && instr_ready && !misaligned) begin
                pc_reg <= target;
            end
        end
    end

    assign pc            = pc_reg;
    assign imem_req_addr = pc_reg;
    assign instruction   = instr_reg;
    assign func_3        = instr_reg[14:12];
    assign func_7_bit_6  = instr_reg[30];
    assign r_type        = class_reg[0];
    assign i_type_lw     = class_reg[1];
    assign i_type_addi   = class_reg[2];
    assign i_type_jalr   = class_reg[3];
    assign s_type        = class_reg[4];
    assign sb_type       = class_reg[5];
    assign u_type_auipc  = class_reg[6];
    assign u_type_lui    = class_reg[7];
    assign uj_type       = class_reg[8];
    assign illegal       = class_reg[9];

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: directed fetch vectors push expected
// request addresses and decodes; a negedge monitor pops and compares them.
module tb_instruction_fetch_unit;

    localparam logic [9:0] C_R     = 10'b00_0000_0001;
    localparam logic [9:0] C_LW    = 10'b00_0000_0010;
    localparam logic [9:0] C_ADDI  = 10'b00_0000_0100;
    localparam logic [9:0] C_JALR  = 10'b00_0000_1000;
    localparam logic [9:0] C_S     = 10'b00_0001_0000;
    localparam logic [9:0] C_SB    = 10'b00_0010_0000;
    localparam logic [9:0] C_AUIPC = 10'b00_0100_0000;
    localparam logic [9:0] C_LUI   = 10'b00_1000_0000;
    localparam logic [9:0] C_UJ    = 10'b01_0000_0000;
    localparam logic [9:0] C_ILL   = 10'b10_0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic        r_type, i_type_lw, i_type_addi, i_type_jalr, s_type, sb_type;
    logic        u_type_auipc, u_type_lui, uj_type;
    logic [2:0]  func_3;
    logic        func_7_bit_6;
    logic        illegal;
    logic [1:0]  next_pc_selector;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] jalr_target;
    logic        halted;

    always #5 clk = ~clk;

    instruction_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instruction(instruction), .pc(pc),
        .r_type(r_type), .i_type_lw(i_type_lw), .i_type_addi(i_type_addi),
        .i_type_jalr(i_type_jalr), .s_type(s_type), .sb_type(sb_type),
        .u_type_auipc(u_type_auipc), .u_type_lui(u_type_lui), .uj_type(uj_type),
        .func_3(func_3), .func_7_bit_6(func_7_bit_6), .illegal(illegal),
        .next_pc_selector(next_pc_selector), .branch_taken(branch_taken),
        .branch_target(branch_target), .jalr_target(jalr_target),
        .halted(halted)
    );

    wire [9:0] cls = {illegal, uj_type, u_type_lui, u_type_auipc, sb_type, s_type,
                      i_type_jalr, i_type_addi, i_type_lw, r_type};

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [9:0]  cls;
    } dec_t;

    dec_t        dec_q[$];
    logic [31:0] addr_q[$];
    int          n_checks = 0;
    int          n_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: compares every accepted request and every newly presented instruction
    logic        prev_valid = 1'b0;
    logic [31:0] mon_addr;
    dec_t        mon_dec;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid <= 1'b0;
        end else begin
            if (imem_req_valid && imem_req_ready) begin
                if (addr_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_req: got addr %0h expected no request", imem_req_addr);
                end else begin
                    mon_addr = addr_q.pop_front();
                    check("req_addr", imem_req_addr, mon_addr);
                end
            end
            if (instr_valid && !prev_valid) begin
                if (dec_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_instr: got %0h expected none", instruction);
                end else begin
                    mon_dec = dec_q.pop_front();
                    check("dec_pc", pc, mon_dec.pc);
                    check("dec_instr", instruction, mon_dec.instr);
                    check("dec_class", cls, mon_dec.cls);
                    check("dec_func3", func_3, mon_dec.instr[14:12]);
                    check("dec_func7b6", func_7_bit_6, mon_dec.instr[30]);
                end
            end
            prev_valid <= instr_valid;
        end
    end

    task automatic do_fetch(input logic [31:0] exp_pc, input logic [31:0] word,
                            input logic [9:0] exp_cls, input logic [1:0] sel,
                            input logic taken, input logic [31:0] btgt,
                            input logic [31:0] jtgt, input int req_stall,
                            input int hold_stall, input logic [31:0] exp_next,
                            input logic exp_halt);
        int t;
        t = 0;
        while (!imem_req_valid && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        if (!imem_req_valid) begin
            n_checks++;
            $display("FAIL req_timeout: got no request expected request at %0h", exp_pc);
            return;
        end
        for (int i = 0; i < req_stall; i++) begin
            imem_req_ready = 1'b0;
            @(posedge clk); #1;
            check("stall_req_valid", imem_req_valid, 1'b1);
            check("stall_req_addr", imem_req_addr, exp_pc);
        end
        addr_q.push_back(exp_pc);
        imem_req_ready = 1'b1;
        @(posedge clk); #1;
        imem_req_ready  = 1'b0;
        dec_q.push_back('{pc: exp_pc, instr: word, cls: exp_cls});
        imem_resp_valid = 1'b1;
        imem_resp_data  = word;
        @(posedge clk); #1;
        imem_resp_valid = 1'b0;
        for (int i = 0; i < hold_stall; i++) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = ~word;
            instr_ready     = 1'b0;
            @(posedge clk); #1;
            check("hold_valid", instr_valid, 1'b1);
            check("hold_instr", instruction, word);
            check("hold_pc", pc, exp_pc);
        end
        imem_resp_valid  = 1'b0;
        next_pc_selector = sel;
        branch_taken     = taken;
        branch_target    = btgt;
        jalr_target      = jtgt;
        instr_ready      = 1'b1;
        @(posedge clk); #1;
        instr_ready = 1'b0;
        if (exp_halt) begin
            check("halt_flag", halted, 1'b1);
            check("halt_no_req", imem_req_valid, 1'b0);
            check("halt_pc", pc, exp_pc);
        end else begin
            check("next_req_valid", imem_req_valid, 1'b1);
            check("next_addr", imem_req_addr, exp_next);
            check("not_halted", halted, 1'b0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        imem_req_ready = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data = 32'd0;
        instr_ready = 1'b0;
        next_pc_selector = 2'b00;
        branch_taken = 1'b0;
        branch_target = 32'd0;
        jalr_target = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pc", pc, 32'h0);
        check("rst_instr", instruction, 32'h0);
        check("rst_class", cls, 10'h0);
        check("rst_func", {func_3, func_7_bit_6}, 4'h0);
        check("rst_instr_valid", instr_valid, 1'b0);
        check("rst_halted", halted, 1'b0);
        check("rst_req_valid", imem_req_valid, 1'b1);
        rst_n = 1'b1;
        check("first_req_addr", imem_req_addr, 32'h0);

        do_fetch(32'h0,        32'h0050_0093, C_ADDI,  2'b00, 1'b0, 32'h0,        32'h0,  0, 0, 32'h4,        1'b0);
        do_fetch(32'h4,        32'h4020_8033, C_R,     2'b00, 1'b0, 32'h0,        32'h0,  5, 4, 32'h8,        1'b0);
        do_fetch(32'h8,        32'h0020_8463, C_SB,    2'b01, 1'b1, 32'h10,       32'h0,  0, 0, 32'h10,       1'b0);
        do_fetch(32'h10,       32'h0000_006f, C_UJ,    2'b11, 1'b0, 32'h8,        32'h77, 1, 2, 32'h8,        1'b0);
        do_fetch(32'h8,        32'h0020_8463, C_SB,    2'b01, 1'b0, 32'h10,       32'h0,  0, 0, 32'hC,        1'b0);
        do_fetch(32'hC,        32'h0000_a103, C_LW,    2'b00, 1'b1, 32'h100,      32'h200,0, 1, 32'h10,       1'b0);
        do_fetch(32'h10,       32'h0000_80e7, C_JALR,  2'b10, 1'b1, 32'h80,       32'h41, 0, 0, 32'h40,       1'b0);
        do_fetch(32'h40,       32'h0000_007f, C_ILL,   2'b00, 1'b0, 32'h0,        32'h0,  0, 0, 32'h44,       1'b0);
        do_fetch(32'h44,       32'h0011_2023, C_S,     2'b11, 1'b0, 32'hFFFF_FFFC,32'h0,  0, 0, 32'hFFFF_FFFC,1'b0);
        do_fetch(32'hFFFF_FFFC,32'h1234_50b7, C_LUI,   2'b00, 1'b0, 32'h0,        32'h0,  0, 0, 32'h0,        1'b0);
        do_fetch(32'h0,        32'h0000_0017, C_AUIPC, 2'b00, 1'b0, 32'h0,        32'h0,  0, 0, 32'h4,        1'b0);
        do_fetch(32'h4,        32'h0000_80e7, C_JALR,  2'b10, 1'b0, 32'h8,        32'h42, 0, 0, 32'h4,        1'b1);

        // Halted: requests stay off even with memory ready
        imem_req_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("halt_sticky", {halted, imem_req_valid, instr_valid}, 3'b100);
            check("halt_pc_hold", pc, 32'h4);
        end
        imem_req_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst2_halted", halted, 1'b0);
        check("rst2_pc", pc, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Reset while a response is outstanding, then a stale response arrives
        addr_q.push_back(32'h0);
        imem_req_ready = 1'b1;
        @(posedge clk); #1;
        imem_req_ready = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #2;
        check("midwait_rst_req", imem_req_valid, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h0050_0093;
        @(posedge clk); #1;
        imem_resp_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("stale_resp_valid", instr_valid, 1'b0);
            check("stale_resp_req", {imem_req_valid, imem_req_addr}, {1'b1, 32'h0});
            check("stale_resp_instr", instruction, 32'h0);
            @(posedge clk); #1;
        end
        do_fetch(32'h0, 32'h0050_0093, C_ADDI, 2'b00, 1'b0, 32'h0, 32'h0, 0, 0, 32'h4, 1'b0);

        repeat (2) @(posedge clk);
        #1;
        check("addr_q_drained", addr_q.size(), 0);
        check("dec_q_drained", dec_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
